fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the instruction ROM. Owns the program counter and drives the ROM address. Presents each fetched instruction word with its PC and a valid flag to decode, with stall hold, redirect, and misaligned-target fault handling. The ROM registers its address on the clock edge, so the data for an address presented in cycle n is visible in cycle n+1. This block is built around that one-cycle latency.

---
 rtl/rv32i.sv | 12 +
 rtl/fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/rv32i.sv
// Shared definitions for the rv32i core pipeline stages.
package rv32i;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address one cycle ahead of
// the registered ROM data, and handles stall hold, redirects and misaligned targets.
module fetch_unit
  import rv32i::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic         r_inst_valid;
  logic         r_fault;
  logic [31:0]  r_fetch_count;

  fetch_state_t w_next_state;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_rom_addr;
  logic         w_next_valid;
  logic         w_next_fault;
  logic         w_accept;

  // The ROM address is the PC we will hold next edge, so ROM data lines up with
  // inst_pc; a misaligned redirect is the one case where the two deliberately differ.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_fetch_pc;
    w_rom_addr   = r_fetch_pc;
    w_next_valid = r_inst_valid;
    w_next_fault = r_fault;
    case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_next_pc    = RESET_PC;
        w_rom_addr   = RESET_PC;
        w_next_valid = 1'b1;
      end
      RUN: begin
        if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
          w_next_pc  = redirect_pc;
          w_rom_addr = redirect_pc;
        end else if (redirect_valid) begin
          w_next_state = FAULT;
          w_next_fault = 1'b1;
          w_next_valid = 1'b0;
          w_next_pc    = redirect_pc;
        end else if (!stall) begin
          w_next_pc  = r_fetch_pc + INST_BYTES;
          w_rom_addr = r_fetch_pc + INST_BYTES;
        end
      end
      FAULT: begin
        w_next_valid = 1'b0;
        w_next_fault = 1'b1;
      end
      default: begin
        w_next_state = BOOT;
        w_next_valid = 1'b0;
      end
    endcase
  end

  assign w_accept = r_inst_valid && !stall && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_inst_valid  <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state      <= w_next_state;
      r_fetch_pc   <= w_next_pc;
      r_inst_valid <= w_next_valid;
      r_fault      <= w_next_fault;
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign rom_addr    = w_rom_addr;
  assign inst        = rom_data;
  assign inst_pc     = r_fetch_pc;
  assign inst_valid  = r_inst_valid;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule
